// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter sharing one single-port RAM between a CPU and a host loader.
// Each access takes three cycles (IDLE sample, ACCESS, ACK); a tie goes to whoever did not win last.
module ram_arbiter #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          cpu_gnt,
  output logic          host_gnt,
  output logic          ram_load,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t state;
  owner_t last_owner;   // also the owner of the access in flight
  logic   lat_we;

  req_t   cpu_r, host_r, win_r;
  owner_t winner;

  always_comb begin
    cpu_r  = '{we: cpu_we,  addr: cpu_addr,  wdata: cpu_wdata};
    host_r = '{we: host_we, addr: host_addr, wdata: host_wdata};
    if (cpu_req && host_req)
      winner = (last_owner == OWN_HOST) ? OWN_CPU : OWN_HOST;
    else if (cpu_req)
      winner = OWN_CPU;
    else
      winner = OWN_HOST;
    win_r = (winner == OWN_CPU) ? cpu_r : host_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWN_HOST;
      lat_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      host_ack   <= 1'b0;
      cpu_gnt    <= 1'b0;
      host_gnt   <= 1'b0;
      ram_load   <= 1'b0;
      ram_addr   <= '0;
      ram_d      <= '0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack  <= 1'b0;
          host_ack <= 1'b0;
          if (cpu_req || host_req) begin
            state      <= ACCESS;
            last_owner <= winner;
            lat_we     <= win_r.we;
            ram_addr   <= win_r.addr;
            ram_d      <= win_r.wdata;
            ram_load   <= win_r.we;
            cpu_gnt    <= (winner == OWN_CPU);
            host_gnt   <= (winner == OWN_HOST);
          end
        end
        ACCESS: begin
          state    <= ACK;
          ram_load <= 1'b0;
          // ram_q follows ram_addr combinationally, so it is valid by the end of ACCESS
          if (!lat_we) begin
            if (last_owner == OWN_CPU) cpu_rdata  <= ram_q;
            else                       host_rdata <= ram_q;
          end
          cpu_ack  <= (last_owner == OWN_CPU);
          host_ack <= (last_owner == OWN_HOST);
        end
        ACK: begin
          state    <= IDLE;
          cpu_ack  <= 1'b0;
          host_ack <= 1'b0;
          cpu_gnt  <= 1'b0;
          host_gnt <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          ram_load <= 1'b0;
          cpu_ack  <= 1'b0;
          host_ack <= 1'b0;
          cpu_gnt  <= 1'b0;
          host_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: transaction-level model predicts grant order and timing,
// a negedge monitor scores gnt/ack/RAM-port/rdata behaviour against the predicted queue.
module tb_ram_arbiter;
  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
  logic [AW-1:0] cpu_addr = '0, host_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, host_wdata = '0;
  logic          cpu_ack, host_ack, cpu_gnt, host_gnt, ram_load;
  logic [DW-1:0] cpu_rdata, host_rdata, ram_d, ram_q;
  logic [AW-1:0] ram_addr;

  ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .cpu_gnt(cpu_gnt), .host_gnt(host_gnt),
    .ram_load(ram_load), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return (a == 12'h0FF) ? 16'h1234 : ({a, 4'h0} ^ 16'h5A5A);
  endfunction

  // RAM model: combinational read, write on the clock edge
  logic [DW-1:0] mem [0:4095];
  bit            mem_v [0:4095];
  always @(posedge clk)
    if (ram_load) begin
      mem[ram_addr]   <= ram_d;
      mem_v[ram_addr] <= 1'b1;
    end
  assign ram_q = mem_v[ram_addr] ? mem[ram_addr] : init_val(ram_addr);

  typedef struct {
    bit            cpu;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_edge;
  } txn_t;

  txn_t q[$];
  int   vectors = 0, miscompares = 0;
  int   edge_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a grant blocks sampling for the next two edges; ties go to the
  // requester that did not win last time.
  int busy = 0;
  bit last_cpu = 0;

  task automatic tick();
    bit   c;
    txn_t t;
    @(posedge clk);
    edge_cnt++;
    if (reset) begin
      busy     = 0;
      last_cpu = 0;
    end else if (busy > 0) begin
      busy--;
    end else if (cpu_req || host_req) begin
      c          = (cpu_req && host_req) ? !last_cpu : cpu_req;
      t.cpu      = c;
      t.we       = c ? cpu_we    : host_we;
      t.addr     = c ? cpu_addr  : host_addr;
      t.wdata    = c ? cpu_wdata : host_wdata;
      t.ack_edge = edge_cnt + 1;
      q.push_back(t);
      last_cpu   = c;
      busy       = 2;
    end
    #1;
  endtask

  // Scoreboard monitor
  logic [DW-1:0] sh [0:4095];
  bit            sh_v [0:4095];
  logic [DW-1:0] exp_crd = '0, exp_hrd = '0, last_d = '0;
  logic [AW-1:0] last_addr = '0;
  txn_t          mt;
  bit            m_acc, m_ack, m_busy;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_crd = '0; exp_hrd = '0; last_addr = '0; last_d = '0;
      chk("reset_ctrl", 32'({cpu_ack, host_ack, cpu_gnt, host_gnt, ram_load}), 32'(0));
      chk("reset_rdata", {cpu_rdata, host_rdata}, 32'(0));
      chk("reset_ram", 32'({ram_addr, ram_d}), 32'(0));
    end else begin
      if (q.size() > 0 && edge_cnt > q[0].ack_edge) begin
        chk("ack_missing", 32'(0), 32'(1));
        void'(q.pop_front());
      end
      m_busy = q.size() > 0;
      m_acc  = m_busy && edge_cnt == q[0].ack_edge - 1;
      m_ack  = m_busy && edge_cnt == q[0].ack_edge;
      chk("gnt", 32'({cpu_gnt, host_gnt}),
          32'({(m_acc || m_ack) && q[0].cpu, (m_acc || m_ack) && !q[0].cpu}));
      chk("ram_load", 32'(ram_load), 32'(m_acc && q[0].we));
      chk("ram_addr", 32'(ram_addr), 32'(m_busy ? q[0].addr : last_addr));
      chk("ram_d", 32'(ram_d), 32'(m_busy ? q[0].wdata : last_d));
      chk("ack", 32'({cpu_ack, host_ack}), 32'({m_ack && q[0].cpu, m_ack && !q[0].cpu}));
      if (m_ack) begin
        mt = q.pop_front();
        if (mt.we) begin
          sh[mt.addr]   = mt.wdata;
          sh_v[mt.addr] = 1'b1;
        end else if (mt.cpu) exp_crd = sh_v[mt.addr] ? sh[mt.addr] : init_val(mt.addr);
        else                 exp_hrd = sh_v[mt.addr] ? sh[mt.addr] : init_val(mt.addr);
        last_addr = mt.addr;
        last_d    = mt.wdata;
      end
      chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
      chk("host_rdata", 32'(host_rdata), 32'(exp_hrd));
    end
  end

  task automatic idle(int n);
    cpu_req = 0; host_req = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_reset_ctrl", 32'({cpu_ack, host_ack, cpu_gnt, host_gnt, ram_load}), 32'(0));
    chk("async_reset_ram", 32'({ram_addr, ram_d}), 32'(0));
    tick(); tick();
    reset = 1'b0;

    // First tie after reset, then continuous contention for 12 cycles
    cpu_req = 1; host_req = 1;
    for (int i = 0; i < 12; i++) begin
      cpu_we = $urandom_range(0, 1);   cpu_addr = 12'($urandom_range(0, 15));
      host_we = $urandom_range(0, 1);  host_addr = 12'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);       host_wdata = 16'($urandom);
      tick();
    end
    idle(5);

    // Single CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h123; cpu_wdata = 16'hBEEF;
    tick();
    cpu_req = 0;
    idle(4);

    // Host read of a preloaded word
    host_req = 1; host_we = 0; host_addr = 12'h0FF;
    tick();
    host_req = 0;
    idle(4);

    // Request withdrawn and address changed after the grant
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h005; cpu_wdata = 16'hA5A5;
    tick();
    cpu_req = 0; cpu_addr = 12'h7FF; cpu_we = 0; cpu_wdata = 16'h0000;
    idle(4);

    // Reset during a host write's ACCESS cycle
    host_req = 1; host_we = 1; host_addr = 12'h0AA; host_wdata = 16'hDEAD;
    tick();
    host_req = 0;
    #2;
    chk("access_load_before_reset", 32'(ram_load), 32'(1));
    reset = 1'b1;
    #1;
    chk("reset_drops_load", 32'({ram_load, host_gnt, host_ack}), 32'(0));
    tick();
    reset = 1'b0;
    idle(4);
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h0AA;
    tick();
    cpu_req = 0;
    idle(4);

    // Randomized traffic on a small address window so reads hit earlier writes
    for (int i = 0; i < 600; i++) begin
      cpu_req  = ($urandom_range(0, 9) < 6);
      host_req = ($urandom_range(0, 9) < 6);
      cpu_we = $urandom_range(0, 1);   cpu_addr = 12'($urandom_range(0, 15));
      host_we = $urandom_range(0, 1);  host_addr = 12'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);       host_wdata = 16'($urandom);
      tick();
    end
    idle(6);
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DW, default 16, data width in bits.
REQ-002 Parameter AW, default 12, address width in bits (4096 words).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous active-high reset.
REQ-006 Port cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-007 Port cpu_we  input  1  CPU write (1) / read (0).
REQ-008 Port cpu_addr  input  AW  CPU word address.
REQ-009 Port cpu_wdata  input  DW  CPU write data.
REQ-010 Port cpu_ack  output  1  one-cycle CPU completion pulse.
REQ-011 Port cpu_rdata  output  DW  CPU read data, registered.
REQ-012 Port host_req, host_we, host_addr, host_wdata  input  1/1/AW/DW  host loader request, same meaning as the CPU ports.
REQ-013 Port host_ack  output  1  one-cycle host completion pulse.
REQ-014 Port host_rdata  output  DW  host read data, registered.
REQ-015 Port cpu_gnt, host_gnt  output  1 each  current owner indication, mutually exclusive.
REQ-016 Port ram_load  output  1  RAM write strobe.
REQ-017 Port ram_addr  output  AW  RAM address.
REQ-018 Port ram_d  output  DW  RAM write data.
REQ-019 Port ram_q  input  DW  RAM read data, combinational from ram_addr.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS and ACK, with transitions IDLE->ACCESS when any req=1, ACCESS->ACK always, and ACK->IDLE always.
REQ-021 Requests SHALL be sampled only in IDLE; on the IDLE->ACCESS edge the owner and the winner's we/addr/wdata SHALL be latched into internal registers.
REQ-022 Arbitration when only one requester is active SHALL grant that requester.
REQ-023 Arbitration when both requesters are active SHALL be round-robin: grant the requester that is not last_owner.
REQ-024 last_owner SHALL update on every grant.
REQ-025 In ACCESS, ram_addr/ram_d SHALL be driven from the latched registers, and ram_load=1 for exactly that cycle when the latched we=1.
REQ-026 ram_load SHALL be 0 in all other states.
REQ-027 In ACCESS with latched we=0, ram_q SHALL be captured at the end of the cycle into the owner's rdata register only; the other rdata SHALL be unchanged.
REQ-028 A write SHALL leave both rdata registers unchanged.
REQ-029 In ACK, the owner's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0.
REQ-030 The gnt of the owner SHALL be 1 in ACCESS and ACK; both gnt SHALL be 0 in IDLE.
REQ-031 Latency SHALL be 2 cycles: req seen at edge N produces ACCESS in cycle N+1 and ack in cycle N+2.
REQ-032 Back-to-back throughput SHALL be one access per 3 cycles.
REQ-033 A requester dropping req after the grant SHALL NOT abort the transaction; it SHALL complete and ack SHALL still pulse.
REQ-034 A req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-035 Input changes on we/addr/wdata after the grant SHALL NOT affect the access in progress.
REQ-036 Starvation bound: with both requesters continuously active, grants SHALL strictly alternate, giving each a worst-case wait of 3 cycles before its own grant.
REQ-037 In IDLE and ACK, ram_addr SHALL hold the last latched address, and ram_d the last latched data.

Reset
REQ-038 On reset=1, immediately and without a clock: state=IDLE; cpu_ack=host_ack=0; cpu_gnt=host_gnt=0; ram_load=0; cpu_rdata=host_rdata=0; ram_addr=0; ram_d=0; last_owner=HOST (CPU wins the first tie).
REQ-039 Reset asserted mid-ACCESS SHALL abort the access: no ack is issued, and ram_load drops in the same cycle.

Verification
REQ-040 Single CPU write: cpu_req=1, we=1, addr=0x123, wdata=0xBEEF -> ram_load=1 for exactly 1 cycle with ram_addr=0x123, ram_d=0xBEEF; cpu_ack two cycles after the request edge; host_ack stays 0.
REQ-041 Host read: RAM word 0x0FF=0x1234, host_req=1, we=0, addr=0x0FF -> host_rdata=0x1234 with host_ack pulse; cpu_rdata unchanged.
REQ-042 Simultaneous first requests after reset: both req=1 -> CPU granted first, host second; the acks are 3 cycles apart; the gnt signals are never both 1.
REQ-043 Continuous contention for 12 cycles -> exactly 4 grants, in the order C,H,C,H.
REQ-044 req withdrawn in ACCESS, and cpu_addr changed in ACCESS -> RAM sees the originally latched address, and cpu_ack still pulses once.
REQ-045 Reset pulsed during a host write's ACCESS cycle -> ram_load falls immediately and no host_ack occurs; the next request is served normally from IDLE.
